// File: rtl/nibble_feeder_pkg.sv
// nibble_feeder_pkg: state encoding and nibble width shared by the nibble feeder
// and its optional timeout counter.
package nibble_feeder_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESENT  = 2'd1,
        ST_WAIT_LOW = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // True in the two states where the block is waiting on the consumer's fim edges.
    function automatic logic is_handshaking(input state_t s);
        return (s == ST_PRESENT) || (s == ST_WAIT_LOW);
    endfunction

endpackage

// File: rtl/nf_timer.sv
// nf_timer: counts enabled cycles since the last clear and flags expiry once
// TIMEOUT cycles have been spent without a clear.
module nf_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Saturate at LIMIT so a stalled owner never sees the count wrap back to zero.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = enable && (count_reg == LIMIT);

endmodule

// File: rtl/nibble_feeder.sv
// nibble_feeder: sweeps a nibble from FIRST to LAST over a 4-phase ready/fim handshake.
// Optional handshake timeout is compiled in with NIBBLE_FEEDER_TIMEOUT_EN.
module nibble_feeder
    import nibble_feeder_pkg::*;
#(
    parameter nibble_t FIRST   = 4'h0,
    parameter nibble_t LAST    = 4'hF,
    parameter int      TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic fim,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic ready,
    output logic busy,
    output logic done,
    output logic error
);

    state_t  state_reg;
    state_t  state_next;
    nibble_t nibble_reg;
    nibble_t nibble_next;
    logic    timeout_hit;

    // A timeout takes priority over a handshake edge arriving in the same cycle.
    always_comb begin
        state_next  = state_reg;
        nibble_next = nibble_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    nibble_next = FIRST;
                    state_next  = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (fim) begin
                    state_next = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (!fim) begin
                    if (nibble_reg == LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        nibble_next = nibble_reg + nibble_t'(1);
                        state_next  = ST_PRESENT;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            nibble_reg <= '0;
        end else begin
            state_reg  <= state_next;
            nibble_reg <= nibble_next;
        end
    end

    assign {a, b, c, d} = nibble_reg;
    assign ready        = (state_reg == ST_PRESENT);
    assign busy         = (state_reg != ST_IDLE);
    assign done         = (state_reg == ST_DONE);

`ifdef NIBBLE_FEEDER_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic error_reg;

    assign timer_enable = is_handshaking(state_reg);
    assign timer_clear  = (state_next != state_reg);

    nf_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timeout_hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_reg <= 1'b0;
        end else if (timeout_hit) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;

    // TIMEOUT only shapes hardware when the counter is compiled in.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

endmodule

// File: tb/tb_nibble_feeder.sv
// tb_nibble_feeder: vector table, hand sequences and a randomized consumer checked
// against handshake rules; covers both NIBBLE_FEEDER_TIMEOUT_EN build variants.
module tb_nibble_feeder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic fim   = 1'b0;
    logic a, b, c, d, ready, busy, done, error;
    logic start9 = 1'b0;
    logic fim9   = 1'b0;
    logic a9, b9, c9, d9, ready9, busy9, done9, error9;
    logic [3:0] nib;
    logic [3:0] nib9;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_rises = 0;
    int done_pulses = 0;
    logic ready_q = 1'b0;

    always #5 clock = ~clock;

    nibble_feeder #(.FIRST(4'h0), .LAST(4'hF), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .fim(fim),
        .a(a), .b(b), .c(c), .d(d),
        .ready(ready), .busy(busy), .done(done), .error(error)
    );

    nibble_feeder #(.FIRST(4'h9), .LAST(4'h9), .TIMEOUT(16)) dut9 (
        .clock(clock), .reset(reset), .start(start9), .fim(fim9),
        .a(a9), .b(b9), .c(c9), .d(d9),
        .ready(ready9), .busy(busy9), .done(done9), .error(error9)
    );

    assign nib  = {a, b, c, d};
    assign nib9 = {a9, b9, c9, d9};

    always @(negedge clock) begin
        if (ready && !ready_q) ready_rises++;
        if (done) done_pulses++;
        ready_q = ready;
    end

    typedef struct packed {
        logic       start;
        logic       fim;
        logic       ready;
        logic       busy;
        logic       done;
        logic [3:0] nib;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int dly;
        int rises0;
        int dones0;
        logic [3:0] exp_nib;

        //            start fim  ready busy done nib
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};  // fim in IDLE ignored
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};  // start; fim already high
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};  // acknowledged on first cycle
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};  // start while busy ignored
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1};  // consumer idle, hold
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3};

        // Reset state
        tick();
        chk("rst_ready", ready, 4'(0));
        chk("rst_busy", busy, 4'(0));
        chk("rst_done", done, 4'(0));
        chk("rst_error", error, 4'(0));
        chk("rst_nib", nib, 4'h0);
        chk("rst_nib9", nib9, 4'h0);
        tick();
        reset = 1'b1;

        // Table-driven opening of a sweep
        for (int i = 0; i < 10; i++) begin
            start = vecs[i].start;
            fim   = vecs[i].fim;
            tick();
            $display("vec %0d: start=%0b fim=%0b -> ready=%0b busy=%0b done=%0b nib=%0h",
                     i, start, fim, ready, busy, done, nib);
            chk($sformatf("vec%0d_ready", i), ready, 4'(vecs[i].ready));
            chk($sformatf("vec%0d_busy", i), busy, 4'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), done, 4'(vecs[i].done));
            chk($sformatf("vec%0d_nib", i), nib, vecs[i].nib);
        end
        start = 1'b0;

        // Reset mid-sweep at nibble 0110
        for (int i = 0; i < 3; i++) begin
            fim = 1'b1; tick();
            fim = 1'b0; tick();
        end
        chk("pre_rst_nib", nib, 4'h6);
        chk("pre_rst_ready", ready, 4'(1));
        #2 reset = 1'b0;
        #1;
        $display("async reset: ready=%0b busy=%0b nib=%0h", ready, busy, nib);
        chk("midrst_ready", ready, 4'(0));
        chk("midrst_busy", busy, 4'(0));
        chk("midrst_nib", nib, 4'h0);
        fim = 1'b1; tick();
        fim = 1'b0; tick();
        reset = 1'b1;
        fim = 1'b1; tick();
        fim = 1'b0; tick();
        chk("postrst_busy", busy, 4'(0));
        chk("postrst_ready", ready, 4'(0));
        chk("postrst_nib", nib, 4'h0);

        // Randomized consumer over a full sweep
        start = 1'b1; tick(); start = 1'b0;
        rises0 = ready_rises;
        dones0 = done_pulses;
        for (int n = 0; n < 16; n++) begin
            exp_nib = 4'h0 + 4'(n);
            chk("sweep_ready", ready, 4'(1));
            chk("sweep_nib", nib, exp_nib);
            dly = int'($urandom_range(0, 3));
            repeat (dly) begin
                tick();
                chk("present_ready", ready, 4'(1));
                chk("present_nib", nib, exp_nib);
            end
            fim = 1'b1; tick();
            chk("ack_ready_drop", ready, 4'(0));
            hold = ((n % 4) == 3) ? 5 : int'($urandom_range(1, 5));
            repeat (hold - 1) begin
                tick();
                chk("slow_ready", ready, 4'(0));
                chk("slow_nib", nib, exp_nib);
                chk("slow_busy", busy, 4'(1));
            end
            fim = 1'b0; tick();
            $display("nibble %0h: delay=%0d hold=%0d", exp_nib, dly, hold);
        end
        chk("sweep_done", done, 4'(1));
        chk("sweep_done_ready", ready, 4'(0));
        chk("sweep_done_nib", nib, 4'hF);
        tick();
        chk("after_done_pulse", done, 4'(0));
        chk("after_done_busy", busy, 4'(0));
        chk("after_done_nib", nib, 4'hF);
        chk("ready_pulses", 4'(ready_rises - rises0), 4'(0));  // 16 wraps to 0 in 4 bits
        n_cmp++;
        if (ready_rises - rises0 != 16) begin
            n_bad++;
            $display("FAIL ready_pulse_count: got %0d, expected 16", ready_rises - rises0);
        end
        chk("done_pulses", 4'(done_pulses - dones0), 4'(1));

        // Single-nibble sweep, FIRST == LAST == 9
        start9 = 1'b1; tick();
        chk("s9_ready", ready9, 4'(1));
        chk("s9_nib", nib9, 4'h9);
        fim9 = 1'b1; tick();
        chk("s9_ack_ready", ready9, 4'(0));
        chk("s9_ack_busy", busy9, 4'(1));
        fim9 = 1'b0; tick();
        chk("s9_done", done9, 4'(1));
        chk("s9_done_nib", nib9, 4'h9);
        tick();
        chk("s9_done_clear", done9, 4'(0));
        chk("s9_idle_busy", busy9, 4'(0));
        start9 = 1'b0; tick();
        chk("s9_idle_ready", ready9, 4'(0));
        chk("s9_hold_nib", nib9, 4'h9);
        chk("s9_error", error9, 4'(0));
        $display("single sweep: nib9=%0h busy9=%0b", nib9, busy9);

`ifdef NIBBLE_FEEDER_TIMEOUT_EN
        // Consumer never answers: error after 16 cycles of ready
        dones0 = done_pulses;
        start = 1'b1; tick(); start = 1'b0;
        chk("to_ready_rise", ready, 4'(1));
        repeat (15) begin
            tick();
            chk("to_wait_ready", ready, 4'(1));
            chk("to_wait_error", error, 4'(0));
        end
        tick();
        chk("to_error", error, 4'(1));
        chk("to_ready", ready, 4'(0));
        chk("to_busy", busy, 4'(0));
        tick();
        chk("to_error_sticky", error, 4'(1));
        chk("to_no_done", 4'(done_pulses - dones0), 4'(0));
        $display("timeout: error=%0b ready=%0b busy=%0b", error, ready, busy);
`else
        // No timeout built: the block waits on fim indefinitely
        start = 1'b1; tick(); start = 1'b0;
        repeat (100) begin
            tick();
            chk("wait_ready", ready, 4'(1));
            chk("wait_error", error, 4'(0));
        end
        chk("wait_nib", nib, 4'h0);
        $display("long wait: ready=%0b error=%0b nib=%0h", ready, error, nib);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_feeder.md
NIBBLE_FEEDER -- requirements
Module: nibble_feeder

Interface
REQ-001 Parameter: FIRST, 4'h0, first nibble value of a sweep.
REQ-002 Parameter: LAST, 4'hF, last nibble value of a sweep; LAST >= FIRST.
REQ-003 Parameter: TIMEOUT, 16, maximum cycles to wait for each handshake edge of fim (only used when the timeout feature is compiled in).
REQ-004 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  sampled in IDLE; high for one cycle begins a sweep.
REQ-007 Port: fim  input  1  acknowledge from the display/decoder consumer (4-phase).
REQ-008 Port: a, b, c, d  output  1 each  presented nibble; a = bit 3 (MSB), d = bit 0.
REQ-009 Port: ready  output  1  nibble on a..d is valid.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse when the sweep completes.
REQ-012 Port: error  output  1  sticky handshake-timeout flag.

Function
REQ-013 The block SHALL implement states IDLE, PRESENT, WAIT_LOW, DONE.
REQ-014 IDLE: start=1 SHALL load nibble = FIRST, assert ready on the next cycle, go to PRESENT; start ignored in all other states.
REQ-015 PRESENT: ready=1, a..d stable; when fim=1 is sampled, ready SHALL drop on the next edge and the state SHALL go to WAIT_LOW.
REQ-016 WAIT_LOW: when fim=0 is sampled, if nibble == LAST go to DONE, else increment nibble and return to PRESENT (ready=1 the following cycle).
REQ-017 Handshake latency: minimum 2 cycles per nibble (ready rise to next ready rise = fim high 1 cycle + fim low 1 cycle); a..d SHALL change only while ready=0.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; a..d hold LAST until the next start.
REQ-019 fim already high on entry to PRESENT SHALL count as acknowledge on the first cycle.
REQ-020 Nibble arithmetic SHALL be 4-bit; no wrap occurs because the sweep ends at LAST (FIRST == LAST gives a single-nibble sweep).
REQ-021 fim toggling while in IDLE or DONE SHALL have no effect.

Reset
REQ-022 reset=0 SHALL immediately force state IDLE, a..d = 0, ready=0, busy=0, done=0, error=0, timer=0, regardless of any in-progress sweep.
REQ-023 Release of reset mid-handshake SHALL leave the block in IDLE awaiting start; no partial nibble is re-presented.

Configuration
REQ-024 Macro NIBBLE_FEEDER_TIMEOUT_EN defined: a cycle counter SHALL run in PRESENT and WAIT_LOW, cleared on each state change; reaching TIMEOUT SHALL set error=1 (sticky until reset), drop ready, and go to IDLE without a done pulse.
REQ-025 Macro undefined: no counter is built, error SHALL be tied to 0, and the block waits indefinitely on fim.

Structure
REQ-026 Package nibble_feeder_pkg SHALL hold the state enumeration and the nibble width constant (4).
REQ-027 Sub-module nf_timer (load/clear, enable, expired output) SHALL implement the timeout counter, instantiated only under NIBBLE_FEEDER_TIMEOUT_EN.

Verification
REQ-028 Full sweep: start pulse, consumer responds fim high 1 cycle after ready, low 1 cycle later -> a..d show 0000..1111 in order, done pulses once after 1111, 16 ready pulses total.
REQ-029 Slow consumer: fim held high 5 cycles per nibble -> ready stays low throughout, a..d unchanged until fim falls, no nibble skipped or repeated.
REQ-030 Reset mid-sweep: reset=0 while nibble=0110 and ready=1 -> ready=0, a..d=0000, busy=0 same cycle; new start restarts at 0000.
REQ-031 Timeout (macro defined, TIMEOUT=16): fim never asserted -> error=1 at cycle 16 after ready, ready=0, busy=0, done never pulses.
REQ-032 Timeout (macro undefined): fim held 0 for 100 cycles -> ready stays 1, error=0, nibble stays FIRST.
REQ-033 FIRST=LAST=4'h9: one handshake -> a..d=1001, done pulses once; start during busy ignored.
